// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between the ALU and MEM (load)
// writeback requesters. The winning request is registered into one output
// stage and reaches the register file one cycle after acceptance. Writes to
// R0 are handshaken but never drive rf_write, so R0 stays zero.
//
// Build option: define WB_ARB_RR_EN to resolve contended cycles round-robin
// instead of fixed MEM priority with the MAX_WAIT starvation override. In
// that build the wait counter is absent and alu_starved is tied low.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   alu_valid/reg/data       ALU writeback request; alu_ready = accepted
//   mem_valid/reg/data       MEM writeback request; mem_ready = accepted
//   flush                    synchronous flush: no grants, stage cleared
//   rf_write/dst_reg/data    register-file write port (registered stage)
//   conflict_cnt             saturating count of both-valid, non-flush cycles
//   alu_starved              starvation override granted ALU this cycle
module regfile_wb_arbiter #(
    parameter int DATA_W   = 16,
    parameter int REG_ID_W = 4,
    parameter int MAX_WAIT = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    input  logic [REG_ID_W-1:0] alu_reg,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  logic [REG_ID_W-1:0] mem_reg,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_ready,
    input  logic                flush,
    output logic                rf_write,
    output logic [REG_ID_W-1:0] rf_dst_reg,
    output logic [DATA_W-1:0]   rf_dst_data,
    output logic [CNT_W-1:0]    conflict_cnt,
    output logic                alu_starved
);

    logic both_valid;
    logic alu_grant;
    logic mem_grant;
    logic stage_valid;

    assign both_valid = alu_valid && mem_valid;

`ifdef WB_ARB_RR_EN
    typedef enum logic {
        PREF_MEM = 1'b0,
        PREF_ALU = 1'b1
    } pref_t;

    pref_t rr_ptr;

    // Uncontended requests win outright; contention follows the pointer.
    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (!flush) begin
            if (both_valid) begin
                alu_grant = (rr_ptr == PREF_ALU);
                mem_grant = (rr_ptr == PREF_MEM);
            end else begin
                alu_grant = alu_valid;
                mem_grant = mem_valid;
            end
        end
    end

    assign alu_starved = 1'b0;

    // Pointer only moves after a contended grant, so lone requests never
    // disturb the fairness order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= PREF_MEM;
        end else if (both_valid && !flush) begin
            rr_ptr <= (rr_ptr == PREF_MEM) ? PREF_ALU : PREF_MEM;
        end
    end
`else
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       override;

    // Once ALU has been denied WAIT_LIMIT cycles in a row it beats MEM.
    assign override = both_valid && !flush && (wait_cnt == WAIT_LIMIT);

    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (!flush) begin
            alu_grant = alu_valid && (!mem_valid || override);
            mem_grant = mem_valid && !alu_grant;
        end
    end

    assign alu_starved = override;

    // Counts consecutive ALU denials; any gap in alu_valid, a grant or a
    // flush starts the count over.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 4'd0;
        end else if (flush || !alu_valid || alu_grant) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`endif

    // Grants already imply valid, so ready can never rise without valid.
    assign alu_ready = alu_grant;
    assign mem_ready = mem_grant;

    // Output stage: register/data hold when nothing is granted so the
    // write port only toggles rf_write between idle cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_valid <= 1'b0;
            rf_dst_reg  <= '0;
            rf_dst_data <= '0;
        end else begin
            stage_valid <= alu_grant || mem_grant;
            if (alu_grant) begin
                rf_dst_reg  <= alu_reg;
                rf_dst_data <= alu_data;
            end else if (mem_grant) begin
                rf_dst_reg  <= mem_reg;
                rf_dst_data <= mem_data;
            end
        end
    end

    // R0 is hardwired zero: accepted writes to it are silently dropped.
    assign rf_write = stage_valid && (rf_dst_reg != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt <= '0;
        end else if (both_valid && !flush && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Directed testbench for regfile_wb_arbiter. Stimulus pushes each expected
// register-file write {reg, data} into a queue; a monitor pops and compares
// whenever rf_write is high. Handshake and status outputs are checked
// directly against hand-computed constants.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_reg;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [3:0]  mem_reg;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        flush;
    logic        rf_write;
    logic [3:0]  rf_dst_reg;
    logic [15:0] rf_dst_data;
    logic [15:0] conflict_cnt;
    logic        alu_starved;

    int tests  = 0;
    int failed = 0;

    logic [19:0] exp_q[$];

    regfile_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_reg      (alu_reg),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_reg      (mem_reg),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .flush        (flush),
        .rf_write     (rf_write),
        .rf_dst_reg   (rf_dst_reg),
        .rf_dst_data  (rf_dst_data),
        .conflict_cnt (conflict_cnt),
        .alu_starved  (alu_starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                                 input logic mv, input logic [3:0] mr, input logic [15:0] md,
                                 input logic fl);
        alu_valid = av;
        alu_reg   = ar;
        alu_data  = ad;
        mem_valid = mv;
        mem_reg   = mr;
        mem_data  = md;
        flush     = fl;
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic expectWrite(input logic [3:0] r, input logic [15:0] d);
        exp_q.push_back({r, d});
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        nextCycle();
    endtask

    // Scoreboard monitor: every register-file write must match the oldest
    // outstanding expectation.
    always @(negedge clk) begin
        if (rf_write === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("[TB] FAIL unexpected_write: got reg %0d data %h, expected no write",
                         rf_dst_reg, rf_dst_data);
            end else begin
                logic [19:0] exp_w;
                exp_w = exp_q.pop_front();
                if ({rf_dst_reg, rf_dst_data} !== exp_w) begin
                    failed++;
                    $display("[TB] FAIL wb_write: got reg %0d data %h, expected reg %0d data %h",
                             rf_dst_reg, rf_dst_data, exp_w[19:16], exp_w[15:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b0;
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        flush = 1'b0;
        #3;
        checkOutput("reset_rf_write", 32'(rf_write), 32'd0);
        checkOutput("reset_dst_reg", 32'(rf_dst_reg), 32'd0);
        checkOutput("reset_dst_data", 32'(rf_dst_data), 32'd0);
        checkOutput("reset_conflict", 32'(conflict_cnt), 32'd0);
        doReset();

        // ALU only
        applyStimulus(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 16'h0, 1'b0);
        checkOutput("alu_only_alu_ready", 32'(alu_ready), 32'd1);
        checkOutput("alu_only_mem_ready", 32'(mem_ready), 32'd0);
        expectWrite(4'd5, 16'hBEEF);
        nextCycle();
        applyIdle();
        checkOutput("alu_only_rf_write", 32'(rf_write), 32'd1);
        checkOutput("alu_only_dst_reg", 32'(rf_dst_reg), 32'd5);
        checkOutput("alu_only_dst_data", 32'(rf_dst_data), 32'hBEEF);
        nextCycle();
        checkOutput("alu_only_write_done", 32'(rf_write), 32'd0);

        // Conflict: MEM first, ALU next cycle
        applyStimulus(1'b1, 4'd3, 16'h1111, 1'b1, 4'd4, 16'h2222, 1'b0);
        checkOutput("conflict_mem_ready", 32'(mem_ready), 32'd1);
        checkOutput("conflict_alu_ready", 32'(alu_ready), 32'd0);
        expectWrite(4'd4, 16'h2222);
        nextCycle();
        applyStimulus(1'b1, 4'd3, 16'h1111, 1'b0, 4'd0, 16'h0, 1'b0);
        checkOutput("conflict_alu_second", 32'(alu_ready), 32'd1);
        expectWrite(4'd3, 16'h1111);
        nextCycle();
        applyIdle();
        checkOutput("conflict_cnt_one", 32'(conflict_cnt), 32'd1);
        nextCycle();

`ifndef WB_ARB_RR_EN
        // Starvation override after three denials
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 4'd6, 16'hA0A0, 1'b1, 4'd7, 16'h7000 + 16'(k), 1'b0);
            checkOutput("starve_mem_ready", 32'(mem_ready), 32'd1);
            checkOutput("starve_alu_denied", 32'(alu_ready), 32'd0);
            checkOutput("starve_flag_low", 32'(alu_starved), 32'd0);
            expectWrite(4'd7, 16'h7000 + 16'(k));
            nextCycle();
        end
        applyStimulus(1'b1, 4'd6, 16'hA0A0, 1'b1, 4'd7, 16'h7003, 1'b0);
        checkOutput("starve_alu_granted", 32'(alu_ready), 32'd1);
        checkOutput("starve_mem_denied", 32'(mem_ready), 32'd0);
        checkOutput("starve_flag_high", 32'(alu_starved), 32'd1);
        expectWrite(4'd6, 16'hA0A0);
        nextCycle();
        applyStimulus(1'b1, 4'd8, 16'h8888, 1'b1, 4'd7, 16'h7003, 1'b0);
        checkOutput("starve_mem_again", 32'(mem_ready), 32'd1);
        checkOutput("starve_alu_again", 32'(alu_ready), 32'd0);
        checkOutput("starve_flag_cleared", 32'(alu_starved), 32'd0);
        expectWrite(4'd7, 16'h7003);
        nextCycle();
        applyIdle();
        checkOutput("starve_conflict_cnt", 32'(conflict_cnt), 32'd6);
        nextCycle();
`endif

        // Write to R0 is accepted but dropped
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'hFFFF, 1'b0);
        checkOutput("r0_mem_ready", 32'(mem_ready), 32'd1);
        nextCycle();
        applyIdle();
        checkOutput("r0_no_write", 32'(rf_write), 32'd0);
        checkOutput("r0_stage_data", 32'(rf_dst_data), 32'hFFFF);
        nextCycle();
        checkOutput("r0_data_holds", 32'(rf_dst_data), 32'hFFFF);
        checkOutput("r0_still_no_write", 32'(rf_write), 32'd0);

        // Reset while the stage holds an accepted write
        applyStimulus(1'b1, 4'd11, 16'h0B0B, 1'b0, 4'd0, 16'h0, 1'b0);
        checkOutput("rst_alu_ready", 32'(alu_ready), 32'd1);
        nextCycle();
        applyIdle();
        rst = 1'b0;
        #1;
        checkOutput("rst_midop_rf_write", 32'(rf_write), 32'd0);
        checkOutput("rst_midop_conflict", 32'(conflict_cnt), 32'd0);
        checkOutput("rst_midop_dst_reg", 32'(rf_dst_reg), 32'd0);
        #1;
        rst = 1'b1;
        nextCycle();

        // Flush: in-flight write completes, no new grants
        applyStimulus(1'b1, 4'd1, 16'h1234, 1'b1, 4'd2, 16'h4321, 1'b0);
        checkOutput("flush_pre_mem_ready", 32'(mem_ready), 32'd1);
        expectWrite(4'd2, 16'h4321);
        nextCycle();
        applyStimulus(1'b1, 4'd1, 16'h1234, 1'b1, 4'd2, 16'h5555, 1'b1);
        checkOutput("flush_alu_ready", 32'(alu_ready), 32'd0);
        checkOutput("flush_mem_ready", 32'(mem_ready), 32'd0);
        checkOutput("flush_inflight_write", 32'(rf_write), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 4'd1, 16'h1234, 1'b0, 4'd0, 16'h0, 1'b0);
        checkOutput("flush_stage_cleared", 32'(rf_write), 32'd0);
        checkOutput("flush_conflict_cnt", 32'(conflict_cnt), 32'd1);
        checkOutput("post_flush_alu_ready", 32'(alu_ready), 32'd1);
        expectWrite(4'd1, 16'h1234);
        nextCycle();
        applyIdle();
        nextCycle();

`ifdef WB_ARB_RR_EN
        // Round-robin: MEM, ALU, MEM, ALU
        doReset();
        applyStimulus(1'b1, 4'd10, 16'hA000, 1'b1, 4'd9, 16'h9000, 1'b0);
        checkOutput("rr0_mem_ready", 32'(mem_ready), 32'd1);
        checkOutput("rr0_alu_ready", 32'(alu_ready), 32'd0);
        expectWrite(4'd9, 16'h9000);
        nextCycle();
        applyStimulus(1'b1, 4'd10, 16'hA000, 1'b1, 4'd9, 16'h9001, 1'b0);
        checkOutput("rr1_alu_ready", 32'(alu_ready), 32'd1);
        checkOutput("rr1_mem_ready", 32'(mem_ready), 32'd0);
        expectWrite(4'd10, 16'hA000);
        nextCycle();
        applyStimulus(1'b1, 4'd10, 16'hA001, 1'b1, 4'd9, 16'h9001, 1'b0);
        checkOutput("rr2_mem_ready", 32'(mem_ready), 32'd1);
        checkOutput("rr2_alu_ready", 32'(alu_ready), 32'd0);
        expectWrite(4'd9, 16'h9001);
        nextCycle();
        applyStimulus(1'b1, 4'd10, 16'hA001, 1'b1, 4'd9, 16'h9002, 1'b0);
        checkOutput("rr3_alu_ready", 32'(alu_ready), 32'd1);
        checkOutput("rr3_starved_tied", 32'(alu_starved), 32'd0);
        expectWrite(4'd10, 16'hA001);
        nextCycle();
        applyIdle();
        nextCycle();
`endif

        nextCycle();
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
